// File: rtl/wb_regfile.sv
// Writeback stage of the pipelined MIPS core: load extraction, writeback select,
// 32x32 register file with write-to-read bypass. Optional trace: WB_TRACE_EN.
module wb_regfile #(
  parameter logic [31:0] LINK_OFFSET = 32'd4,
  parameter logic [31:0] SP_INIT     = 32'h0000_0000,
  parameter logic [31:0] GP_INIT     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        regwrite_w,
  input  logic [1:0]  memtoreg_w,
  input  logic [31:0] ir_w,
  input  logic [31:0] pc4_w,
  input  logic [31:0] aluout_w,
  input  logic [31:0] dm_w,
  input  logic [4:0]  a3sel_w,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] wb_data,
  output logic        wb_we
);

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101
  } load_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  logic [31:0] regs_q [32];
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;

  // Only the opcode field of the instruction matters here.
  logic unused_ir;
  assign unused_ir = &{1'b0, ir_w[25:0]};

  always_comb begin
    byte_d = dm_w[7:0];
    case (aluout_w[1:0])
      2'd0: byte_d = dm_w[7:0];
      2'd1: byte_d = dm_w[15:8];
      2'd2: byte_d = dm_w[23:16];
      2'd3: byte_d = dm_w[31:24];
    endcase
    half_d = aluout_w[1] ? dm_w[31:16] : dm_w[15:0];

    load_d = dm_w;
    case (ir_w[31:26])
      OP_LB:   load_d = {{24{byte_d[7]}}, byte_d};
      OP_LBU:  load_d = {24'h0, byte_d};
      OP_LH:   load_d = {{16{half_d[15]}}, half_d};
      OP_LHU:  load_d = {16'h0, half_d};
      OP_LW:   load_d = dm_w;
      default: load_d = dm_w;
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (memtoreg_w)
      WB_ALU:  wb_data = aluout_w;
      WB_MEM:  wb_data = load_d;
      WB_LINK: wb_data = pc4_w + LINK_OFFSET;
      WB_ZERO: wb_data = '0;
    endcase
  end

  assign wb_we = regwrite_w & (a3sel_w != 5'd0) & clr_n;

  // Reset takes priority so a reset cycle discards the instruction in WB.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i[4:0]] <= '0;
      end
      regs_q[28] <= GP_INIT;
      regs_q[29] <= SP_INIT;
    end else if (wb_we) begin
      regs_q[a3sel_w] <= wb_data;
    end
  end

  always_comb begin
    if (ra1 == 5'd0)                      rd1 = '0;
    else if (wb_we && (ra1 == a3sel_w))   rd1 = wb_data;
    else                                  rd1 = regs_q[ra1];
  end

  always_comb begin
    if (ra2 == 5'd0)                      rd2 = '0;
    else if (wb_we && (ra2 == a3sel_w))   rd2 = wb_data;
    else                                  rd2 = regs_q[ra2];
  end

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (wb_we) begin
      $display("@%h: $%d <= %h", pc4_w - 32'd4, a3sel_w, wb_data);
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed test-plan steps followed by random traffic,
// checked against an arithmetic reference model of the register file.
module tb_wb_regfile;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic        clk = 1'b0;
  logic        clr_n, regwrite_w;
  logic [1:0]  memtoreg_w;
  logic [31:0] ir_w, pc4_w, aluout_w, dm_w;
  logic [4:0]  a3sel_w, ra1, ra2;
  logic [31:0] rd1, rd2, wb_data;
  logic        wb_we;

  int unsigned checks = 0, passes = 0, fails = 0;
  logic [31:0] model [32];
  logic [31:0] obs_rd1, obs_rd2;
  logic        obs_we;

  always #5 clk = ~clk;

  wb_regfile #(
    .LINK_OFFSET(32'd4),
    .SP_INIT(SP),
    .GP_INIT(GP)
  ) dut (
    .clk(clk), .clr_n(clr_n), .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
    .ir_w(ir_w), .pc4_w(pc4_w), .aluout_w(aluout_w), .dm_w(dm_w),
    .a3sel_w(a3sel_w), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wb_data(wb_data), .wb_we(wb_we)
  );

  function automatic logic [31:0] irop(input logic [5:0] op);
    return {op, 26'h0};
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] v, input int bits, input bit sgn);
    logic [31:0] m;
    m = (32'h1 << bits) - 32'h1;
    v = v & m;
    if (sgn && v[bits-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_wb(input logic [1:0] mt, input logic [31:0] ir,
                                         input logic [31:0] pc4, input logic [31:0] alu,
                                         input logic [31:0] dm);
    int unsigned off;
    logic [31:0] ld;
    off = alu[1:0];
    case (ir[31:26])
      6'h20:   ld = ext(dm >> (8 * off), 8, 1'b1);
      6'h24:   ld = ext(dm >> (8 * off), 8, 1'b0);
      6'h21:   ld = ext(dm >> (16 * (off / 2)), 16, 1'b1);
      6'h25:   ld = ext(dm >> (16 * (off / 2)), 16, 1'b0);
      default: ld = dm;
    endcase
    case (mt)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc4 + 32'd4;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic rw, input logic [1:0] mt,
                     input logic [31:0] ir, input logic [31:0] pc4,
                     input logic [31:0] alu, input logic [31:0] dm,
                     input logic [4:0] a3, input logic [4:0] r1, input logic [4:0] r2);
    logic        e_we;
    logic [31:0] e_wb, e_rd1, e_rd2;
    @(negedge clk);
    clr_n = c; regwrite_w = rw; memtoreg_w = mt; ir_w = ir; pc4_w = pc4;
    aluout_w = alu; dm_w = dm; a3sel_w = a3; ra1 = r1; ra2 = r2;
    #1;
    e_we  = rw && (a3 != 5'd0) && c;
    e_wb  = ref_wb(mt, ir, pc4, alu, dm);
    e_rd1 = (r1 == 5'd0) ? 32'h0 : (e_we && r1 == a3) ? e_wb : model[r1];
    e_rd2 = (r2 == 5'd0) ? 32'h0 : (e_we && r2 == a3) ? e_wb : model[r2];
    chk("wb_we",   {31'b0, wb_we}, {31'b0, e_we});
    chk("wb_data", wb_data, e_wb);
    chk("rd1",     rd1, e_rd1);
    chk("rd2",     rd2, e_rd2);
    obs_rd1 = rd1; obs_rd2 = rd2; obs_we = wb_we;
    @(posedge clk);
    if (!c) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[28] = GP;
      model[29] = SP;
    end else if (e_we) begin
      model[a3] = e_wb;
    end
  endtask

  logic [5:0]  ld_ops  [6] = '{6'h20, 6'h24, 6'h20, 6'h21, 6'h25, 6'h23};
  logic [1:0]  ld_offs [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exps [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                               32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
  logic [5:0]  rnd_ops [6] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h0F};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rnd, rir;
    logic [4:0]  ra3, rr1, rr2;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset held two cycles with a pending write
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'hDEAD, 32'h0, 5'd5, 5'd0, 5'd0);
    chk("reset_we0", {31'b0, obs_we}, 32'h0);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'hDEAD, 32'h0, 5'd5, 5'd0, 5'd0);
    chk("reset_we1", {31'b0, obs_we}, 32'h0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd28);
    chk("reset_r5", obs_rd1, 32'h0);
    chk("reset_gp", obs_rd2, GP);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd29, 5'd0);
    chk("reset_sp", obs_rd1, SP);

    // ALU write with bypass, then array read
    cyc(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 5'd8, 5'd8, 5'd8);
    chk("alu_bypass1", obs_rd1, 32'h1234_5678);
    chk("alu_bypass2", obs_rd2, 32'h1234_5678);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
    chk("alu_array", obs_rd1, 32'h1234_5678);

    // Load extraction into $9
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b1, 2'd1, irop(ld_ops[i]), 32'h0, {30'h0, ld_offs[i]}, 32'h80FF_7F01,
          5'd9, 5'd0, 5'd9);
      chk("load_bypass", obs_rd2, ld_exps[i]);
      cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
      chk("load_array", obs_rd1, ld_exps[i]);
    end

    // Link address, including wrap
    cyc(1'b1, 1'b1, 2'd2, 32'h0, 32'h0000_3004, 32'h0, 32'h0, 5'd31, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0);
    chk("link", obs_rd1, 32'h0000_3008);
    cyc(1'b1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd31, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31);
    chk("link_wrap", obs_rd2, 32'h0000_0002);

    // $0 protection
    cyc(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_we", {31'b0, obs_we}, 32'h0);
    chk("r0_rd1", obs_rd1, 32'h0);
    chk("r0_rd2", obs_rd2, 32'h0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    chk("r0_next", obs_rd1, 32'h0);

    // Reset mid-stream discards the write in WB
    cyc(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd10, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    chk("mid_pre", obs_rd1, 32'hA5A5_A5A5);
    cyc(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 32'h1, 32'h0, 5'd10, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd29);
    chk("mid_r10", obs_rd1, 32'h0);
    chk("mid_sp", obs_rd2, SP);
    cyc(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h77, 32'h0, 5'd10, 5'd0, 5'd0);
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    chk("mid_post", obs_rd1, 32'h77);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rnd = $urandom();
      rir = {rnd_ops[$urandom_range(0, 5)], rnd[25:0]};
      rnd = $urandom();
      ra3 = rnd[4:0];
      rr1 = rnd[9] ? ra3 : rnd[14:10];
      rr2 = rnd[15] ? ra3 : rnd[20:16];
      cyc(($urandom_range(0, 31) != 0), rnd[21], rnd[23:22], rir, $urandom(),
          $urandom(), $urandom(), ra3, rr1, rr2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline register outputs in the pipelined MIPS core.
- Selects writeback data (ALU result, extended load data, or link address) and performs load byte/halfword extraction and extension.
- Owns the 32x32 general-purpose register file and provides two combinational read ports with internal write-to-read bypass for the decode stage.
- Also drives wb_data/wb_we for the hazard/forwarding logic.

Parameters:
- LINK_OFFSET, 4, constant added to pc4_w to form the link address (PC+8).
- SP_INIT, 32'h0000_0000, reset value of $29.
- GP_INIT, 32'h0000_0000, reset value of $28.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr_n  in  1  synchronous, active-low reset.
- regwrite_w  in  1  write enable from MEM/WB.
- memtoreg_w  in  2  writeback source select.
- ir_w  in  32  instruction in WB; opcode ir_w[31:26] selects load width/sign.
- pc4_w  in  32  PC+4 of the WB instruction.
- aluout_w  in  32  ALU result; [1:0] is the load byte offset.
- dm_w  in  32  raw word read from data memory.
- a3sel_w  in  5  destination register number.
- ra1  in  5  read address port 1.
- ra2  in  5  read address port 2.
- rd1  out  32  read data port 1.
- rd2  out  32  read data port 2.
- wb_data  out  32  selected writeback value, for forwarding.
- wb_we  out  1  effective write enable: regwrite_w & (a3sel_w!=0) & clr_n.

Behaviour:
- Reset: on posedge clk with clr_n=0, all registers clear to 0, except $28=GP_INIT and $29=SP_INIT. No write occurs that cycle, even if regwrite_w=1.
- Reset is checked before the write, so reset mid-stream discards the WB instruction's write.
- Writeback select:
  - memtoreg_w=00 -> aluout_w
  - 01 -> load data
  - 10 -> pc4_w+LINK_OFFSET (mod 2^32)
  - 11 -> 32'h0
- Load data, by opcode:
  - lw (100011) -> dm_w.
  - lb (100000) / lbu (100100) -> byte dm_w[8*off+7:8*off], off=aluout_w[1:0], sign/zero extended.
  - lh (100001) / lhu (100101) -> halfword dm_w[16*off[1]+15:16*off[1]], sign/zero extended; off[0] ignored.
  - Any other opcode -> dm_w unchanged.
- Write: at posedge clk when wb_we=1, reg[a3sel_w] <= wb_data. Single-cycle latency; the value is visible in the array from the next cycle.
- $0: never written; always reads 0.
- Reads (combinational):
  - rdN = 0 if raN==0.
  - Else wb_data if wb_we=1 and raN==a3sel_w (same-cycle bypass).
  - Else reg[raN].
- Both ports may hit the same register, and both may bypass in the same cycle.
- wb_data and wb_we are purely combinational from the inputs. wb_we=0 during reset.
- The block performs no internal stalls. Every cycle is independent; a bubble (regwrite_w=0, all-zero inputs from a cleared MEM/WB) has no effect.

Optional Feature:
- Macro: WB_TRACE_EN.
- Defined: on each posedge with wb_we=1, simulation emits one line "@%h: $%d <= %h" with pc4_w-4, a3sel_w, wb_data. Nothing is printed for $0 or for suppressed writes. Non-synthesisable; no port or timing change.
- Undefined: no trace code is compiled; functionality is identical.

Test Plan:
- Reset: hold clr_n=0 for 2 cycles with regwrite_w=1, a3sel_w=5, aluout_w=32'hDEAD -> afterwards ra1=5 reads 0, ra1=29 reads SP_INIT, ra2=28 reads GP_INIT, wb_we=0 while in reset.
- ALU write and bypass: regwrite_w=1, memtoreg_w=00, a3sel_w=8, aluout_w=32'h1234_5678, ra1=8 -> rd1=32'h1234_5678 in the same cycle (bypass); next cycle with regwrite_w=0, rd1 still reads 32'h1234_5678 (array).
- Loads: dm_w=32'h80FF_7F01, memtoreg_w=01, each case written to $9 and read back:
  - lb off=3 -> 32'hFFFF_FF80
  - lbu off=3 -> 32'h0000_0080
  - lb off=1 -> 32'h0000_007F
  - lh off=2 -> 32'hFFFF_80FF
  - lhu off=0 -> 32'h0000_7F01
  - lw -> 32'h80FF_7F01
- Link: memtoreg_w=10, pc4_w=32'h0000_3004, a3sel_w=31 -> $31 = 32'h0000_3008; with pc4_w=32'hFFFF_FFFE -> 32'h0000_0002 (wrap).
- $0 protection: regwrite_w=1, a3sel_w=0, aluout_w=32'hFFFF_FFFF, ra1=ra2=0 -> rd1=rd2=0 and wb_we=0; next cycle still 0.
- Reset mid-stream: write $10=32'hA5A5_A5A5, then drop clr_n=0 for one cycle while presenting a write of 32'h1 to $10 -> $10 reads 0 after reset; next write with clr_n=1 succeeds.
